// File: rtl/pkt_pkg.sv
// Shared definitions for the switch port packet reader: FSM state encoding,
// pkt_err bit positions and header byte offsets.
package pkt_pkg;

  typedef enum logic [1:0] {
    ADDR    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } state_t;

  localparam int ERR_PARITY  = 0;
  localparam int ERR_ADDR    = 1;
  localparam int ERR_LEN     = 2;
  localparam int ERR_TIMEOUT = 3;

  // Byte positions within a packet; payload starts right after the header.
  localparam int HDR_ADDR  = 0;
  localparam int HDR_LEN   = 1;
  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/pkt_raw_buf.sv
// Two-entry byte FIFO that holds bytes captured from the switch port until
// the reassembly FSM consumes them. Push and pop may occur in the same cycle.
module pkt_raw_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [1:0] occ
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; the caller guarantees no overflow/underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/pkt_port_reader.sv
// Drains one switch output port, reassembles addr/len/payload/parity packets,
// streams the payload downstream and reports per-packet status.
// Optional mid-packet idle timeout is built when PKT_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ADDR    | waiting for the destination address byte
// LEN     | waiting for the length byte; bad length ends the packet
// PAYLOAD | presenting payload bytes downstream, counter = bytes left
// PARITY  | waiting for the parity byte, then reporting status
module pkt_port_reader
  import pkt_pkg::*;
#(
  parameter int MAX_LEN        = 64,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  output logic             read,
  input  logic [7:0]       port,
  input  logic [7:0]       port_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             pkt_done,
  output logic [3:0]       pkt_err,
  output logic [CNT_W-1:0] pkt_count
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state;
  logic       pending;
  logic [1:0] occ;
  logic [7:0] head;
  logic       buf_pop;
  logic [7:0] addr_reg;
  logic [7:0] acc;
  logic [7:0] len_reg;
  logic [7:0] remain;
  logic       addr_mis;
  logic       len_bad;
  logic [3:0] err_len;
  logic [3:0] err_par;
  logic       tmo_fire;

  // Never request more bytes than the raw buffer can still absorb.
  assign read = ready && (({1'b0, occ} + {2'b00, pending}) < 3'd2);

  // An accepted pop delivers its byte on port one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= 1'b0;
    else       pending <= read && ready;
  end

  pkt_raw_buf u_raw_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (pending),
    .push_data (port),
    .pop       (buf_pop),
    .head      (head),
    .occ       (occ)
  );

  // Downstream presentation and buffer consumption for the current state.
  always_comb begin
    out_valid = (state == PAYLOAD) && (occ != 2'd0);
    out_data  = head;
    out_sop   = (state == PAYLOAD) && (remain == len_reg);
    out_eop   = (state == PAYLOAD) && (remain == 8'd1);
    buf_pop   = 1'b0;
    case (state)
      PAYLOAD: buf_pop = out_valid && out_ready;
      default: buf_pop = (occ != 2'd0);
    endcase
  end

  // Status vectors reported with pkt_done.
  always_comb begin
    addr_mis              = (addr_reg != port_addr);
    len_bad               = (head == 8'd0) || (head > MAX_LEN_B);
    err_len               = '0;
    err_len[ERR_LEN]      = 1'b1;
    err_len[ERR_ADDR]     = addr_mis;
    err_par               = '0;
    err_par[ERR_PARITY]   = (head != acc);
    err_par[ERR_ADDR]     = addr_mis;
  end

`ifdef PKT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] idle_cnt;
  logic             stall;

  assign stall    = out_valid && !out_ready;
  assign tmo_fire = (state != ADDR) && !buf_pop && !stall && (idle_cnt == '0);

  // Idle down-counter: reloads on any progress, fires at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if ((state == ADDR) || buf_pop || stall) begin
      idle_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - TMO_W'(1);
    end
  end
`else
  // Feature compiled out: a stalled packet waits indefinitely.
  assign tmo_fire = (TIMEOUT_CYCLES < 0);
`endif

  // Reassembly FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ADDR;
      addr_reg  <= '0;
      acc       <= '0;
      len_reg   <= '0;
      remain    <= '0;
      pkt_done  <= 1'b0;
      pkt_err   <= '0;
      pkt_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (tmo_fire) begin
        pkt_done             <= 1'b1;
        pkt_err              <= '0;
        pkt_err[ERR_TIMEOUT] <= 1'b1;
        pkt_count            <= pkt_count + CNT_W'(1);
        state                <= ADDR;
      end else begin
        case (state)
          ADDR: begin
            if (buf_pop) begin
              addr_reg <= head;
              acc      <= head;
              state    <= LEN;
            end
          end
          LEN: begin
            if (buf_pop) begin
              acc <= acc ^ head;
              if (len_bad) begin
                pkt_done  <= 1'b1;
                pkt_err   <= err_len;
                pkt_count <= pkt_count + CNT_W'(1);
                state     <= ADDR;
              end else begin
                len_reg <= head;
                remain  <= head;
                state   <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (buf_pop) begin
              acc    <= acc ^ head;
              remain <= remain - 8'd1;
              if (remain == 8'd1) state <= PARITY;
            end
          end
          PARITY: begin
            if (buf_pop) begin
              pkt_done  <= 1'b1;
              pkt_err   <= err_par;
              pkt_count <= pkt_count + CNT_W'(1);
              state     <= ADDR;
            end
          end
          default: state <= ADDR;
        endcase
      end
    end
  end

endmodule
